// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one single-ported memory
// between an instruction-fetch port (I) and a load/store port (D).
// Each accepted command is held on the memory for LATENCY cycles, then the
// winner gets a one-cycle response strobe (read data or write acknowledge).
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              i_req_ready,
  output logic              i_rsp_valid,
  input  logic              d_req_valid,
  input  logic              d_req_write,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int              CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic            PORT_I   = 1'b0;
  localparam logic            PORT_D   = 1'b1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_grant_q, last_grant_d;
  logic                winner_q, winner_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic                i_rsp_q, i_rsp_d;
  logic                d_rsp_q, d_rsp_d;
  logic                busy_q, busy_d;

  logic                grant_i;
  logic                grant_d;
  logic                accept;

  // Round-robin pick: a lone requester wins; on a tie the port not granted last wins.
  // Ready is masked while rst_n is low so nothing handshakes during reset.
  always_comb begin
    grant_i     = i_req_valid && (!d_req_valid || (last_grant_q == PORT_D));
    grant_d     = d_req_valid && !grant_i;
    accept      = rst_n && (state_q == IDLE) && (i_req_valid || d_req_valid);
    i_req_ready = accept && grant_i;
    d_req_ready = accept && grant_d;
  end

  // Next-state and registered-output computation for the IDLE/ACCESS/RESP sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    i_rsp_d      = 1'b0;
    d_rsp_d      = 1'b0;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = ACCESS;
          cnt_d        = CNT_INIT;
          winner_d     = grant_d ? PORT_D : PORT_I;
          last_grant_d = grant_d ? PORT_D : PORT_I;
          wr_d         = grant_d ? d_req_write : i_req_write;
          addr_d       = grant_d ? d_req_addr  : i_req_addr;
          wdata_d      = grant_d ? d_req_wdata : i_req_wdata;
          // Write strobe only in the first access cycle; read held for all of them.
          mem_read_d   = grant_d ? !d_req_write : !i_req_write;
          mem_write_d  = grant_d ?  d_req_write :  i_req_write;
          busy_d       = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (!wr_q) begin
            rdata_d = mem_rdata;
          end
          i_rsp_d = (winner_q == PORT_I);
          d_rsp_d = (winner_q == PORT_D);
        end else begin
          cnt_d      = cnt_q - 1'b1;
          mem_read_d = !wr_q;
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; async reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= PORT_D;
      winner_q     <= PORT_I;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      i_rsp_q      <= 1'b0;
      d_rsp_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      i_rsp_q      <= i_rsp_d;
      d_rsp_q      <= d_rsp_d;
      busy_q       <= busy_d;
    end
  end

  assign i_rsp_valid = i_rsp_q;
  assign d_rsp_valid = d_rsp_q;
  assign rsp_rdata   = rdata_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed vectors on a LATENCY=2 instance and a
// LATENCY=1 instance; expected responses go into per-instance queues that a
// negedge monitor pops whenever a response strobe appears.
module tb_mem_arbiter;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;

  // LATENCY=2 instance signals
  logic        i_req_valid, i_req_write, i_req_ready, i_rsp_valid;
  logic [31:0] i_req_addr, i_req_wdata;
  logic        d_req_valid, d_req_write, d_req_ready, d_rsp_valid;
  logic [31:0] d_req_addr, d_req_wdata;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, busy;

  // LATENCY=1 instance signals
  logic        b_i_req_valid, b_i_req_write, b_i_req_ready, b_i_rsp_valid;
  logic [31:0] b_i_req_addr, b_i_req_wdata;
  logic        b_d_req_valid, b_d_req_write, b_d_req_ready, b_d_rsp_valid;
  logic [31:0] b_d_req_addr, b_d_req_wdata;
  logic [31:0] b_rsp_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_mem_read, b_mem_write, b_busy;

  int ntests = 0;
  int nfail  = 0;
  exp_t sb0[$];
  exp_t sb1[$];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_write(i_req_write), .i_req_addr(i_req_addr),
    .i_req_wdata(i_req_wdata), .i_req_ready(i_req_ready), .i_rsp_valid(i_rsp_valid),
    .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready), .d_rsp_valid(d_rsp_valid),
    .rsp_rdata(rsp_rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(b_i_req_valid), .i_req_write(b_i_req_write), .i_req_addr(b_i_req_addr),
    .i_req_wdata(b_i_req_wdata), .i_req_ready(b_i_req_ready), .i_rsp_valid(b_i_rsp_valid),
    .d_req_valid(b_d_req_valid), .d_req_write(b_d_req_write), .d_req_addr(b_d_req_addr),
    .d_req_wdata(b_d_req_wdata), .d_req_ready(b_d_req_ready), .d_rsp_valid(b_d_rsp_valid),
    .rsp_rdata(b_rsp_rdata), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Memory models: words never written read back as 0xDEADBEEF.
  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];
  bit   [255:0] wr0;
  bit   [255:0] wr1;

  always @(posedge clk) begin
    if (mem_write) begin
      mem0[mem_addr[9:2]] <= mem_wdata;
      wr0[mem_addr[9:2]]  <= 1'b1;
    end
    if (b_mem_write) begin
      mem1[b_mem_addr[9:2]] <= b_mem_wdata;
      wr1[b_mem_addr[9:2]]  <= 1'b1;
    end
  end

  assign mem_rdata   = wr0[mem_addr[9:2]]   ? mem0[mem_addr[9:2]]   : 32'hDEADBEEF;
  assign b_mem_rdata = wr1[b_mem_addr[9:2]] ? mem1[b_mem_addr[9:2]] : 32'hDEADBEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push0(input logic port, input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    sb0.push_back(e);
  endtask

  task automatic push1(input logic port, input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    sb1.push_back(e);
  endtask

  task automatic nc();
    @(posedge clk);
    #2;
  endtask

  task automatic smp();
    #2;
  endtask

  // Response monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (i_rsp_valid || d_rsp_valid) begin
      if (sb0.size() == 0) begin
        chk("dut rsp unexpected", {30'd0, i_rsp_valid, d_rsp_valid}, 32'd0);
      end else begin
        e = sb0.pop_front();
        chk("dut rsp port", {i_rsp_valid, d_rsp_valid}, e.port ? 32'd1 : 32'd2);
        chk("dut rsp_rdata", rsp_rdata, e.data);
      end
    end
    if (b_i_rsp_valid || b_d_rsp_valid) begin
      if (sb1.size() == 0) begin
        chk("dut1 rsp unexpected", {30'd0, b_i_rsp_valid, b_d_rsp_valid}, 32'd0);
      end else begin
        e = sb1.pop_front();
        chk("dut1 rsp port", {b_i_rsp_valid, b_d_rsp_valid}, e.port ? 32'd1 : 32'd2);
        chk("dut1 rsp_rdata", b_rsp_rdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    i_req_valid = 1'b1; i_req_write = 1'b0; i_req_addr = '0; i_req_wdata = '0;
    d_req_valid = 1'b0; d_req_write = 1'b0; d_req_addr = '0; d_req_wdata = '0;
    b_i_req_valid = 1'b0; b_i_req_write = 1'b0; b_i_req_addr = '0; b_i_req_wdata = '0;
    b_d_req_valid = 1'b0; b_d_req_write = 1'b0; b_d_req_addr = '0; b_d_req_wdata = '0;

    // Reset state, with a request already pending on I
    repeat (2) @(posedge clk);
    #4;
    chk("rst i_req_ready", i_req_ready, 0);
    chk("rst d_req_ready", d_req_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst mem_read", mem_read, 0);
    chk("rst mem_write", mem_write, 0);
    chk("rst rsp_valid", {i_rsp_valid, d_rsp_valid}, 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    i_req_valid = 1'b0;
    nc();
    rst_n = 1'b1;

    // Single read of 0x40
    nc();
    i_req_valid = 1'b1; i_req_write = 1'b0; i_req_addr = 32'h40;
    smp();
    chk("rd c0 i_req_ready", i_req_ready, 1);
    chk("rd c0 d_req_ready", d_req_ready, 0);
    chk("rd c0 busy", busy, 0);
    push0(1'b0, 32'hDEADBEEF);
    nc();
    i_req_valid = 1'b0; i_req_addr = '0;
    smp();
    chk("rd c1 mem_read", mem_read, 1);
    chk("rd c1 mem_addr", mem_addr, 32'h40);
    chk("rd c1 busy", busy, 1);
    chk("rd c1 i_rsp_valid", i_rsp_valid, 0);
    nc();
    smp();
    chk("rd c2 mem_read", mem_read, 1);
    chk("rd c2 mem_addr", mem_addr, 32'h40);
    chk("rd c2 i_rsp_valid", i_rsp_valid, 0);
    nc();
    smp();
    chk("rd c3 mem_read", mem_read, 0);
    chk("rd c3 i_rsp_valid", i_rsp_valid, 1);
    chk("rd c3 busy", busy, 1);

    // Write 0x1234 to 0x80, accepted in cycle 4 of the read
    nc();
    d_req_valid = 1'b1; d_req_write = 1'b1; d_req_addr = 32'h80; d_req_wdata = 32'h1234;
    smp();
    chk("wr c0 d_req_ready", d_req_ready, 1);
    chk("wr c0 i_rsp_valid", i_rsp_valid, 0);
    push0(1'b1, 32'hDEADBEEF);
    nc();
    d_req_valid = 1'b0; d_req_wdata = '0;
    smp();
    chk("wr c1 mem_write", mem_write, 1);
    chk("wr c1 mem_read", mem_read, 0);
    chk("wr c1 mem_addr", mem_addr, 32'h80);
    chk("wr c1 mem_wdata", mem_wdata, 32'h1234);
    nc();
    smp();
    chk("wr c2 mem_write", mem_write, 0);
    chk("wr c2 mem_read", mem_read, 0);
    nc();
    smp();
    chk("wr c3 mem_write", mem_write, 0);
    chk("wr c3 d_rsp_valid", d_rsp_valid, 1);

    // Read back 0x80
    nc();
    d_req_valid = 1'b1; d_req_write = 1'b0; d_req_addr = 32'h80;
    smp();
    chk("rb c0 d_req_ready", d_req_ready, 1);
    push0(1'b1, 32'h1234);
    nc();
    d_req_valid = 1'b0;
    smp();
    chk("rb c1 mem_read", mem_read, 1);
    chk("rb c1 mem_addr", mem_addr, 32'h80);
    nc();
    nc();
    smp();
    chk("rb c3 d_rsp_valid", d_rsp_valid, 1);

    // Payload changes after accept
    nc();
    i_req_valid = 1'b1; i_req_write = 1'b0; i_req_addr = 32'h10;
    smp();
    chk("pl c0 i_req_ready", i_req_ready, 1);
    push0(1'b0, 32'hDEADBEEF);
    nc();
    i_req_valid = 1'b0; i_req_addr = 32'h20; i_req_write = 1'b1;
    smp();
    chk("pl c1 mem_addr", mem_addr, 32'h10);
    chk("pl c1 mem_read", mem_read, 1);
    nc();
    smp();
    chk("pl c2 mem_addr", mem_addr, 32'h10);
    chk("pl c2 mem_read", mem_read, 1);
    chk("pl c2 mem_write", mem_write, 0);
    nc();
    smp();
    chk("pl c3 i_rsp_valid", i_rsp_valid, 1);
    i_req_write = 1'b0;
    nc();

    // Tie after reset: both ports held valid, grants I, D, I
    rst_n = 1'b0;
    nc();
    rst_n = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      nc();
      i_req_valid = 1'b1; i_req_addr = 32'h40;
      d_req_valid = 1'b1; d_req_write = 1'b0; d_req_addr = 32'h80;
      smp();
      chk($sformatf("tie c%0d i_req_ready", c), i_req_ready, (c == 0 || c == 8) ? 1 : 0);
      chk($sformatf("tie c%0d d_req_ready", c), d_req_ready, (c == 4) ? 1 : 0);
      chk($sformatf("tie c%0d d_rsp_valid", c), d_rsp_valid, (c == 7) ? 1 : 0);
      if (c == 0 || c == 8) push0(1'b0, 32'hDEADBEEF);
      if (c == 4) push0(1'b1, 32'h1234);
    end
    nc();
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    repeat (4) nc();

    // Reset during the first ACCESS cycle of a read
    i_req_valid = 1'b1; i_req_addr = 32'h40;
    smp();
    chk("ra c0 i_req_ready", i_req_ready, 1);
    push0(1'b0, 32'hDEADBEEF);
    nc();
    i_req_valid = 1'b0;
    smp();
    chk("ra c1 mem_read", mem_read, 1);
    chk("ra c1 busy", busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ra async mem_read", mem_read, 0);
    chk("ra async mem_write", mem_write, 0);
    chk("ra async busy", busy, 0);
    chk("ra async rsp_valid", {i_rsp_valid, d_rsp_valid}, 0);
    sb0.delete();
    nc();
    rst_n = 1'b1;
    repeat (3) nc();
    i_req_valid = 1'b1; i_req_addr = 32'h40;
    d_req_valid = 1'b1; d_req_addr = 32'h80;
    smp();
    chk("ra tie i_req_ready", i_req_ready, 1);
    chk("ra tie d_req_ready", d_req_ready, 0);
    push0(1'b0, 32'hDEADBEEF);
    nc();
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    repeat (4) nc();

    // LATENCY=1: D held valid, grants every 3 cycles
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) nc();
      b_d_req_valid = 1'b1; b_d_req_write = 1'b0; b_d_req_addr = 32'h80;
      smp();
      chk($sformatf("l1 c%0d d_req_ready", c), b_d_req_ready, (c % 3 == 0) ? 1 : 0);
      chk($sformatf("l1 c%0d mem_read", c), b_mem_read, (c % 3 == 1) ? 1 : 0);
      chk($sformatf("l1 c%0d d_rsp_valid", c), b_d_rsp_valid, (c % 3 == 2) ? 1 : 0);
      if (c % 3 == 0) push1(1'b1, 32'hDEADBEEF);
    end
    nc();
    b_d_req_valid = 1'b0;
    repeat (3) nc();

    chk("sb0 drained", sb0.size(), 0);
    chk("sb1 drained", sb1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
